// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit for a 5-stage pipeline.
// Issues one bus transfer per memory op (IDLE -> BUSY -> DONE), stalls the
// pipeline while the transfer is outstanding, formats load data and places
// store data on the correct byte lanes. A bounded wait turns a missing
// dmem_ack into bus_err instead of hanging the pipeline.
// Optional feature: define MEM_STAGE_LSU_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses (no bus request, mem_misalign raised in DONE).
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        r_n,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic        MemtoReg_mem,
  input  logic        RegWrite_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] rs2Data_mem,
  input  logic [4:0]  rdAddr_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic [31:0] MemDout_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  rdAddr_out,
  output logic        mem_misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [31:0] data_r;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        bus_err_r;
  logic        mis_r;

  logic        op_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [1:0]  off_s;
  logic        trap_s;

  // Select the addressed lane of a read word and sign/zero extend it.
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    if (off[1]) h = word[31:16];
    else        h = word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, b};
      3'b101:  res = {16'h0000, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign op_s = MemRead_mem | MemWrite_mem;

  // Decode access size into byte enables, replicated store data, load lane and trap.
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    off_s   = 2'b00;
    trap_s  = 1'b0;
    case (funct3_mem[1:0])
      2'b00: begin
        be_s    = 4'b0001 << ALUResult_mem[1:0];
        wdata_s = {4{rs2Data_mem[7:0]}};
        off_s   = ALUResult_mem[1:0];
      end
      2'b01: begin
        if (ALUResult_mem[1]) be_s = 4'b1100;
        else                  be_s = 4'b0011;
        wdata_s = {2{rs2Data_mem[15:0]}};
        off_s   = {ALUResult_mem[1], 1'b0};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = rs2Data_mem;
        off_s   = 2'b00;
      end
    endcase
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
    case (funct3_mem[1:0])
      2'b00:   trap_s = 1'b0;
      2'b01:   trap_s = ALUResult_mem[0];
      default: trap_s = |ALUResult_mem[1:0];
    endcase
`else
    trap_s = 1'b0;
`endif
  end

  // Transfer FSM with registered bus interface, wait counter and status flags.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= 32'h0000_0000;
      be_r      <= 4'b0000;
      wdata_r   <= 32'h0000_0000;
      data_r    <= 32'h0000_0000;
      f3_r      <= 3'b000;
      off_r     <= 2'b00;
      bus_err_r <= 1'b0;
      mis_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r     <= 8'd0;
          bus_err_r <= 1'b0;
          mis_r     <= 1'b0;
          if (op_s) begin
            data_r <= 32'h0000_0000;
            if (trap_s) begin
              // Misaligned access: skip the bus and report in DONE.
              state_r <= DONE;
              mis_r   <= 1'b1;
            end else begin
              state_r <= BUSY;
              req_r   <= 1'b1;
              we_r    <= MemWrite_mem;
              addr_r  <= {ALUResult_mem[31:2], 2'b00};
              be_r    <= be_s;
              wdata_r <= wdata_s;
              f3_r    <= funct3_mem;
              off_r   <= off_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          cnt_r <= cnt_r + 8'd1;
          if (dmem_ack) begin
            state_r <= DONE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            if (we_r) data_r <= 32'h0000_0000;
            else      data_r <= format_load(dmem_rdata, f3_r, off_r);
          end else if (cnt_r == (TIMEOUT_C - 8'd1)) begin
            state_r   <= DONE;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            data_r    <= 32'h0000_0000;
            bus_err_r <= 1'b1;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          cnt_r     <= 8'd0;
          bus_err_r <= 1'b0;
          mis_r     <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 8'd0;
          req_r     <= 1'b0;
          we_r      <= 1'b0;
          bus_err_r <= 1'b0;
          mis_r     <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline-facing outputs: stall, writeback control and load data.
  always_comb begin
    stall_mem   = 1'b0;
    MemDout_out = 32'h0000_0000;
    case (state_r)
      IDLE:    stall_mem = op_s;
      BUSY:    stall_mem = 1'b1;
      DONE:    MemDout_out = data_r;
      default: stall_mem = 1'b0;
    endcase
  end

  // bus_err and mis_r are only ever set while in DONE, so they gate writeback there.
  assign RegWrite_out  = RegWrite_mem & ~bus_err_r & ~mis_r;
  assign MemtoReg_out  = MemtoReg_mem;
  assign ALUResult_out = ALUResult_mem;
  assign rdAddr_out    = rdAddr_mem;
  assign dmem_req      = req_r;
  assign dmem_we       = we_r;
  assign dmem_addr     = addr_r;
  assign dmem_be       = be_r;
  assign dmem_wdata    = wdata_r;
  assign bus_err       = bus_err_r;
  assign mem_misalign  = mis_r;

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum BUSY cycles waited for dmem_ack, range 1..255.
REQ-002 Ports, one per line: name direction width meaning.
- clk in 1: single clock, rising edge.
- r_n in 1: reset, asynchronous, active-low.
- MemRead_mem in 1: load in MEM stage.
- MemWrite_mem in 1: store in MEM stage.
- funct3_mem in 3: size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- MemtoReg_mem in 1: writeback select.
- RegWrite_mem in 1: writeback enable.
- ALUResult_mem in 32: effective address / ALU result.
- rs2Data_mem in 32: store data.
- rdAddr_mem in 5: destination register.
- dmem_req out 1: bus request, registered.
- dmem_we out 1: write strobe, registered.
- dmem_addr out 32: word address, bits[1:0]=00, registered.
- dmem_be out 4: byte enables, registered.
- dmem_wdata out 32: lane-aligned store data, registered.
- dmem_ack in 1: transfer complete, one-cycle pulse.
- dmem_rdata in 32: read word, valid with dmem_ack.
- stall_mem out 1: freeze IF..EX/MEM and hold MEM/WB register enable low.
- MemtoReg_out, RegWrite_out out 1 each: to MEM/WB register.
- MemDout_out out 32: formatted load data.
- ALUResult_out out 32: pass-through of ALUResult_mem.
- rdAddr_out out 5: pass-through of rdAddr_mem.
- mem_misalign out 1: misaligned access flag.
- bus_err out 1: timeout flag.

Function
REQ-003 FSM states IDLE, BUSY, DONE; IDLE is the reset state.
REQ-004 IDLE, no MemRead_mem/MemWrite_mem: stall_mem=0; outputs are a combinational pass-through; MemDout_out=0.
REQ-005 IDLE, memory op: stall_mem=1; register dmem_addr/be/wdata/we; dmem_req=1; next state BUSY.
REQ-006 BUSY: stall_mem=1; dmem_req and the bus registers hold stable; the 8-bit wait counter increments each cycle.
REQ-007 BUSY with dmem_ack=1: dmem_req=0 on the next edge; the formatted load word is captured into the data register; next state DONE.
REQ-008 BUSY, counter reaches TIMEOUT with no ack: dmem_req=0; bus_err=1 in DONE; RegWrite_out forced 0; next state DONE.
REQ-009 DONE: stall_mem=0; MemDout_out = data register; the instruction advances at this edge; next state IDLE.
REQ-010 Minimum memory-op occupancy is 3 cycles (IDLE, BUSY with immediate ack, DONE).
REQ-011 Store byte enables: sb gives 1<<addr[1:0] with byte replicated on all lanes; sh gives 0011 or 1100 by addr[1] with halfword replicated; sw gives 1111.
REQ-012 Loads select the lane by addr[1:0]; lb/lh sign-extend, lbu/hu zero-extend, lw passes the word through.
REQ-013 A dmem_ack outside BUSY is ignored; MemRead_mem and MemWrite_mem both set is treated as a store.

Reset
REQ-014 r_n low, asynchronous at any time including mid-BUSY: state IDLE, counter 0, dmem_req/we 0, dmem_addr/be/wdata 0, data register 0, bus_err 0, mem_misalign 0.
REQ-015 After r_n releases, the first edge behaves as IDLE; an abandoned transfer is not reissued.

Configuration
REQ-016 Macro MEM_STAGE_LSU_MISALIGN_TRAP_EN defined: h/hu/sh at addr[0]=1, or w/sw at addr[1:0]!=0, issues no bus request; the FSM goes IDLE to DONE; mem_misalign=1 in DONE; RegWrite_out=0.
REQ-017 Macro undefined: mem_misalign is tied 0; halfword ops ignore addr[0]; word ops ignore addr[1:0].

Verification
REQ-018 lw at 0x100, ack on the first BUSY cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111; DONE MemDout 0xDEADBEEF; stall high for exactly 2 cycles.
REQ-019 lb at 0x103, rdata 0x80000000 -> MemDout 0xFFFFFF80; lbu gives 0x00000080.
REQ-020 sh at 0x202, rs2 0x1234ABCD -> be 1100, wdata 0xABCDABCD, we=1.
REQ-021 TIMEOUT=4, no ack -> dmem_req high for 4 cycles; bus_err=1 with RegWrite_out=0 in DONE.
REQ-022 r_n pulsed low mid-BUSY -> dmem_req=0 immediately; state IDLE; a late ack causes no capture.
REQ-023 With the macro: lw at 0x101 -> no dmem_req; mem_misalign=1 for 1 cycle; RegWrite_out=0.
